// File: rtl/gaussian_window_filter.sv
// Gaussian window filter: latches a Q2.14 kernel once per reset, then filters SIZE x SIZE
// pixel windows with a sequential MAC. Define GAUSS_FILTER_SATURATE_EN to clamp the output.
module gaussian_window_filter #(
  parameter int SIZE            = 5,
  parameter int PIXEL_WIDTH     = 8,
  parameter int FRACTIONAL_BITS = 14,
  parameter int ACC_WIDTH       = 40
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                kernel_valid,
  input  logic [SIZE*SIZE*16-1:0]             kernel_matrix,
  output logic                                kernel_loaded,
  input  logic                                win_valid,
  output logic                                win_ready,
  input  logic [SIZE*SIZE*PIXEL_WIDTH-1:0]    window,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PIXEL_WIDTH-1:0]              out_pixel
);

  localparam int COEF_W = 16;
  localparam int IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX =
    {{(ACC_WIDTH-PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    WAIT_KERNEL,
    IDLE,
    ACCUM,
    NORM,
    OUTPUT
  } state_t;

  state_t state, next_state;

  logic signed [COEF_W-1:0]      kern_q [SIZE][SIZE];
  logic        [PIXEL_WIDTH-1:0] win_q  [SIZE][SIZE];
  logic signed [ACC_WIDTH-1:0]   acc;
  logic        [IDX_W-1:0]       row_idx, col_idx;
  logic signed [ACC_WIDTH-1:0]   pix_ext, coef_ext, product;
  logic                          last_elem;

  // Round half up: add one half LSB of the result, then arithmetic shift.
  function automatic logic signed [ACC_WIDTH-1:0] round_frac(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] half;
    logic signed [ACC_WIDTH-1:0] sum;
    half = '0;
    half[FRACTIONAL_BITS-1] = 1'b1;
    sum = a + half;
    return sum >>> FRACTIONAL_BITS;
  endfunction

  function automatic logic [PIXEL_WIDTH-1:0] clamp_pixel(
    input logic signed [ACC_WIDTH-1:0] r
  );
`ifdef GAUSS_FILTER_SATURATE_EN
    if (r[ACC_WIDTH-1])
      return '0;
    else if (r > PIX_MAX)
      return {PIXEL_WIDTH{1'b1}};
    else
      return r[PIXEL_WIDTH-1:0];
`else
    return r[PIXEL_WIDTH-1:0];
`endif
  endfunction

  assign last_elem = (row_idx == LAST_IDX) && (col_idx == LAST_IDX);

  // Pixel is zero-extended so it stays non-negative in the signed product.
  always_comb begin
    pix_ext  = {{(ACC_WIDTH-PIXEL_WIDTH){1'b0}}, win_q[row_idx][col_idx]};
    coef_ext = {{(ACC_WIDTH-COEF_W){kern_q[row_idx][col_idx][COEF_W-1]}},
                kern_q[row_idx][col_idx]};
    product  = pix_ext * coef_ext;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= WAIT_KERNEL;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    win_ready  = 1'b0;
    case (state)
      WAIT_KERNEL: if (kernel_valid) next_state = IDLE;
      IDLE: begin
        win_ready = 1'b1;
        if (win_valid) next_state = ACCUM;
      end
      ACCUM:       if (last_elem) next_state = NORM;
      NORM:        next_state = OUTPUT;
      OUTPUT:      if (out_ready) next_state = IDLE;
      default:     next_state = WAIT_KERNEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kernel_loaded <= 1'b0;
      out_valid     <= 1'b0;
      out_pixel     <= '0;
      acc           <= '0;
      row_idx       <= '0;
      col_idx       <= '0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          kern_q[r][c] <= '0;
          win_q[r][c]  <= '0;
        end
      end
    end else begin
      case (state)
        WAIT_KERNEL: begin
          if (kernel_valid) begin
            kernel_loaded <= 1'b1;
            for (int r = 0; r < SIZE; r++)
              for (int c = 0; c < SIZE; c++)
                kern_q[r][c] <= kernel_matrix[(r*SIZE+c)*COEF_W +: COEF_W];
          end
        end
        IDLE: begin
          if (win_valid) begin
            acc     <= '0;
            row_idx <= '0;
            col_idx <= '0;
            for (int r = 0; r < SIZE; r++)
              for (int c = 0; c < SIZE; c++)
                win_q[r][c] <= window[(r*SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH];
          end
        end
        ACCUM: begin
          acc <= acc + product;
          // Indices hold on the final element so they never leave the array.
          if (!last_elem) begin
            if (col_idx == LAST_IDX) begin
              col_idx <= '0;
              row_idx <= row_idx + 1'b1;
            end else begin
              col_idx <= col_idx + 1'b1;
            end
          end
        end
        NORM: begin
          out_pixel <= clamp_pixel(round_frac(acc));
          out_valid <= 1'b1;
        end
        OUTPUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gaussian_window_filter.sv
// Directed bench for gaussian_window_filter with hand-computed expected pixels.
module tb_gaussian_window_filter;

  localparam int SIZE   = 5;
  localparam int PW     = 8;
  localparam int NE     = SIZE * SIZE;
  localparam int CENTER = (SIZE/2) * SIZE + SIZE/2;
  localparam int LAT    = NE + 1;

`ifdef GAUSS_FILTER_SATURATE_EN
  localparam logic [PW-1:0] EXP_OVF = 8'd255;
  localparam logic [PW-1:0] EXP_NEG = 8'd0;
`else
  localparam logic [PW-1:0] EXP_OVF = 8'd144;
  localparam logic [PW-1:0] EXP_NEG = 8'd156;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              kernel_valid;
  logic [NE*16-1:0]  kmat;
  logic              kernel_loaded;
  logic              win_valid;
  logic              win_ready;
  logic [NE*PW-1:0]  win;
  logic              out_valid;
  logic              out_ready;
  logic [PW-1:0]     out_pixel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gaussian_window_filter #(
    .SIZE(SIZE), .PIXEL_WIDTH(PW), .FRACTIONAL_BITS(14), .ACC_WIDTH(40)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .kernel_valid(kernel_valid), .kernel_matrix(kmat), .kernel_loaded(kernel_loaded),
    .win_valid(win_valid), .win_ready(win_ready), .window(win),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel_center(input logic [15:0] c);
    kmat = '0;
    kmat[CENTER*16 +: 16] = c;
  endtask

  task automatic set_kernel_all(input logic [15:0] c);
    for (int k = 0; k < NE; k++) kmat[k*16 +: 16] = c;
  endtask

  task automatic set_window_center(input logic [PW-1:0] p);
    win = '0;
    win[CENTER*PW +: PW] = p;
  endtask

  task automatic set_window_all(input logic [PW-1:0] p);
    for (int k = 0; k < NE; k++) win[k*PW +: PW] = p;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load_kernel(input string tag);
    kernel_valid = 1'b1;
    tick();
    kernel_valid = 1'b0;
    check({tag, "_kload"}, kernel_loaded, 1);
  endtask

  task automatic run_window(input string tag, input logic [PW-1:0] exp);
    int n;
    n = 0;
    check({tag, "_rdy"}, win_ready, 1);
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_pix"}, out_pixel, exp);
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_vld_low"}, out_valid, 0);
    check({tag, "_rdy_back"}, win_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset_n      = 1'b0;
    kernel_valid = 1'b0;
    win_valid    = 1'b0;
    out_ready    = 1'b1;
    kmat         = '0;
    win          = '0;
    #3;
    check("rst_kload", kernel_loaded, 0);
    check("rst_rdy", win_ready, 0);
    check("rst_vld", out_valid, 0);
    check("rst_pix", out_pixel, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Window offered before any kernel: must be refused.
    set_window_center(8'd200);
    set_kernel_center(16'd16384);
    win_valid = 1'b1;
    repeat (3) tick();
    check("prek_rdy", win_ready, 0);
    check("prek_kload", kernel_loaded, 0);
    check("prek_vld", out_valid, 0);

    // Kernel and window on the same edge: only the kernel is taken.
    kernel_valid = 1'b1;
    tick();
    kernel_valid = 1'b0;
    check("same_kload", kernel_loaded, 1);
    check("same_rdy", win_ready, 1);
    check("same_vld", out_valid, 0);
    run_window("ident", 8'd200);
    finish_out("ident");

    // A second kernel_valid must not replace the captured kernel.
    set_kernel_all(16'd0);
    kernel_valid = 1'b1;
    tick();
    kernel_valid = 1'b0;
    run_window("kreload", 8'd200);
    finish_out("kreload");

    do_reset();
    set_kernel_all(16'd655);
    load_kernel("unif");
    set_window_all(8'd255);
    run_window("unif", 8'd255);
    finish_out("unif");

    do_reset();
    set_kernel_center(16'd32767);
    load_kernel("ovf");
    set_window_center(8'd200);
    run_window("ovf", EXP_OVF);
    finish_out("ovf");

    do_reset();
    set_kernel_center(16'hC000);
    load_kernel("neg");
    set_window_center(8'd100);
    run_window("neg", EXP_NEG);
    finish_out("neg");

    // 0.5 * 201 = 100.5 rounds up to 101.
    do_reset();
    set_kernel_center(16'd8192);
    load_kernel("rnd");
    set_window_center(8'd201);
    run_window("rnd", 8'd101);
    finish_out("rnd");

    // Backpressure: output held for 10 cycles.
    out_ready = 1'b0;
    set_window_center(8'd201);
    run_window("bp", 8'd101);
    set_window_center(8'd3);
    win_valid = 1'b1;
    repeat (10) begin
      tick();
      check("bp_vld", out_valid, 1);
      check("bp_hold", out_pixel, 101);
      check("bp_rdy", win_ready, 0);
    end
    win_valid = 1'b0;
    finish_out("bp");

    // Reset in the middle of ACCUM discards the result and the kernel.
    set_window_center(8'd50);
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    #1;
    check("mid_kload", kernel_loaded, 0);
    check("mid_rdy", win_ready, 0);
    check("mid_vld", out_valid, 0);
    check("mid_pix", out_pixel, 0);
    #2;
    reset_n = 1'b1;
    win_valid = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid || win_ready) seen = 1'b1;
    end
    win_valid = 1'b0;
    check("mid_quiet", seen, 0);
    set_kernel_center(16'd16384);
    load_kernel("post");
    set_window_center(8'd77);
    run_window("post", 8'd77);
    finish_out("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
